// File: rtl/ysyx_23060203_axi_if.sv
// AXI4 bundle shared by the LSU port and the memory/device slaves.
// Modport "in" is seen by the slave side of a link, "out" by the master side.
interface ysyx_23060203_axi_if;
  logic        arvalid;
  logic        arready;
  logic [31:0] araddr;
  logic [3:0]  arid;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        rvalid;
  logic        rready;
  logic [1:0]  rresp;
  logic [31:0] rdata;
  logic        rlast;
  logic [3:0]  rid;
  logic        awvalid;
  logic        awready;
  logic [31:0] awaddr;
  logic [3:0]  awid;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        wvalid;
  logic        wready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        bvalid;
  logic        bready;
  logic [1:0]  bresp;
  logic [3:0]  bid;

  modport in (
    input  arvalid, araddr, arid, arlen, arsize, arburst, rready,
    output arready, rvalid, rresp, rdata, rlast, rid,
    input  awvalid, awaddr, awid, awlen, awsize, awburst,
    input  wvalid, wdata, wstrb, wlast, bready,
    output awready, wready, bvalid, bresp, bid
  );

  modport out (
    output arvalid, araddr, arid, arlen, arsize, arburst, rready,
    input  arready, rvalid, rresp, rdata, rlast, rid,
    output awvalid, awaddr, awid, awlen, awsize, awburst,
    output wvalid, wdata, wstrb, wlast, bready,
    input  awready, wready, bvalid, bresp, bid
  );
endinterface

// File: rtl/ysyx_23060203_xbar.sv
// AXI4 router: LSU -> SRAM / UART / CLINT, unmapped addresses get DECERR.
// Ports: clock, reset (sync high), lsu (in), sram/uart/clint (out).
module ysyx_23060203_xbar #(
  parameter logic [31:0] UART_BASE  = 32'h1000_0000,
  parameter logic [31:0] UART_MASK  = 32'hFFFF_F000,
  parameter logic [31:0] CLINT_BASE = 32'h0200_0000,
  parameter logic [31:0] CLINT_MASK = 32'hFFFF_0000,
  parameter logic [31:0] SRAM_BASE  = 32'h8000_0000,
  parameter logic [31:0] SRAM_MASK  = 32'hF800_0000
) (
  input logic clock,
  input logic reset,
  ysyx_23060203_axi_if.in  lsu,
  ysyx_23060203_axi_if.out sram,
  ysyx_23060203_axi_if.out uart,
  ysyx_23060203_axi_if.out clint
);

  typedef enum logic [1:0] {T_SRAM, T_UART, T_CLINT, T_ERR} tgt_e;
  typedef enum logic [1:0] {R_IDLE, R_FWD, R_ERR} rstate_e;
  typedef enum logic [1:0] {W_IDLE, W_FWD, W_ERR} wstate_e;

  function automatic tgt_e decode(input logic [31:0] a);
    if ((a & UART_MASK) == UART_BASE)        return T_UART;
    else if ((a & CLINT_MASK) == CLINT_BASE) return T_CLINT;
    else if ((a & SRAM_MASK) == SRAM_BASE)   return T_SRAM;
    else                                     return T_ERR;
  endfunction

  rstate_e    rstate, rnext;
  wstate_e    wstate, wnext;
  tgt_e       rtgt, wtgt, rdec, wdec;
  logic [7:0] rlen, rcnt;
  logic [3:0] rid_q, wid_q;
  logic       r_acc, w_acc, w_done;

  assign rdec = decode(lsu.araddr);
  assign wdec = decode(lsu.awaddr);

  // r_acc/w_acc: error AR/AW already acknowledged; w_done: all W beats eaten
  always_ff @(posedge clock) begin
    if (reset) begin
      rstate <= R_IDLE;
      rtgt   <= T_SRAM;
      rlen   <= '0;
      rcnt   <= '0;
      rid_q  <= '0;
      r_acc  <= 1'b0;
    end else begin
      rstate <= rnext;
      unique case (rstate)
        R_IDLE: if (lsu.arvalid) begin
          rtgt  <= rdec;
          rlen  <= lsu.arlen;
          rid_q <= lsu.arid;
          rcnt  <= '0;
          r_acc <= 1'b0;
        end
        R_ERR: begin
          if (!r_acc) r_acc <= 1'b1;
          else if (lsu.rready) rcnt <= rcnt + 8'd1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wstate <= W_IDLE;
      wtgt   <= T_SRAM;
      wid_q  <= '0;
      w_acc  <= 1'b0;
      w_done <= 1'b0;
    end else begin
      wstate <= wnext;
      unique case (wstate)
        W_IDLE: if (lsu.awvalid) begin
          wtgt   <= wdec;
          wid_q  <= lsu.awid;
          w_acc  <= 1'b0;
          w_done <= 1'b0;
        end
        W_ERR: begin
          w_acc <= 1'b1;
          if (!w_done && lsu.wvalid && lsu.wlast) w_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    rnext = rstate;
    {sram.arvalid, sram.araddr, sram.arid} = '0;
    {sram.arlen, sram.arsize, sram.arburst, sram.rready} = '0;
    {uart.arvalid, uart.araddr, uart.arid} = '0;
    {uart.arlen, uart.arsize, uart.arburst, uart.rready} = '0;
    {clint.arvalid, clint.araddr, clint.arid} = '0;
    {clint.arlen, clint.arsize, clint.arburst, clint.rready} = '0;
    {lsu.arready, lsu.rvalid, lsu.rresp} = '0;
    {lsu.rdata, lsu.rlast, lsu.rid} = '0;
    unique case (rstate)
      R_IDLE: if (lsu.arvalid) rnext = (rdec == T_ERR) ? R_ERR : R_FWD;
      R_FWD: begin
        unique case (rtgt)
          T_UART: begin
            uart.arvalid = lsu.arvalid; uart.araddr  = lsu.araddr;
            uart.arid    = lsu.arid;    uart.arlen   = lsu.arlen;
            uart.arsize  = lsu.arsize;  uart.arburst = lsu.arburst;
            uart.rready  = lsu.rready;
            lsu.arready  = uart.arready; lsu.rvalid = uart.rvalid;
            lsu.rresp    = uart.rresp;   lsu.rdata  = uart.rdata;
            lsu.rlast    = uart.rlast;   lsu.rid    = uart.rid;
          end
          T_CLINT: begin
            clint.arvalid = lsu.arvalid; clint.araddr  = lsu.araddr;
            clint.arid    = lsu.arid;    clint.arlen   = lsu.arlen;
            clint.arsize  = lsu.arsize;  clint.arburst = lsu.arburst;
            clint.rready  = lsu.rready;
            lsu.arready   = clint.arready; lsu.rvalid = clint.rvalid;
            lsu.rresp     = clint.rresp;   lsu.rdata  = clint.rdata;
            lsu.rlast     = clint.rlast;   lsu.rid    = clint.rid;
          end
          default: begin
            sram.arvalid = lsu.arvalid; sram.araddr  = lsu.araddr;
            sram.arid    = lsu.arid;    sram.arlen   = lsu.arlen;
            sram.arsize  = lsu.arsize;  sram.arburst = lsu.arburst;
            sram.rready  = lsu.rready;
            lsu.arready  = sram.arready; lsu.rvalid = sram.rvalid;
            lsu.rresp    = sram.rresp;   lsu.rdata  = sram.rdata;
            lsu.rlast    = sram.rlast;   lsu.rid    = sram.rid;
          end
        endcase
        if (lsu.rvalid && lsu.rready && lsu.rlast) rnext = R_IDLE;
      end
      R_ERR: begin
        lsu.arready = !r_acc;
        lsu.rvalid  = r_acc;
        lsu.rresp   = r_acc ? 2'b11 : 2'b00;
        lsu.rid     = r_acc ? rid_q : 4'd0;
        lsu.rlast   = r_acc && (rcnt == rlen);
        if (r_acc && lsu.rready && rcnt == rlen) rnext = R_IDLE;
      end
      default: rnext = R_IDLE;
    endcase
  end

  always_comb begin
    wnext = wstate;
    {sram.awvalid, sram.awaddr, sram.awid, sram.awlen} = '0;
    {sram.awsize, sram.awburst, sram.wvalid, sram.wdata} = '0;
    {sram.wstrb, sram.wlast, sram.bready} = '0;
    {uart.awvalid, uart.awaddr, uart.awid, uart.awlen} = '0;
    {uart.awsize, uart.awburst, uart.wvalid, uart.wdata} = '0;
    {uart.wstrb, uart.wlast, uart.bready} = '0;
    {clint.awvalid, clint.awaddr, clint.awid, clint.awlen} = '0;
    {clint.awsize, clint.awburst, clint.wvalid, clint.wdata} = '0;
    {clint.wstrb, clint.wlast, clint.bready} = '0;
    {lsu.awready, lsu.wready, lsu.bvalid, lsu.bresp, lsu.bid} = '0;
    unique case (wstate)
      W_IDLE: if (lsu.awvalid) wnext = (wdec == T_ERR) ? W_ERR : W_FWD;
      W_FWD: begin
        unique case (wtgt)
          T_UART: begin
            uart.awvalid = lsu.awvalid; uart.awaddr  = lsu.awaddr;
            uart.awid    = lsu.awid;    uart.awlen   = lsu.awlen;
            uart.awsize  = lsu.awsize;  uart.awburst = lsu.awburst;
            uart.wvalid  = lsu.wvalid;  uart.wdata   = lsu.wdata;
            uart.wstrb   = lsu.wstrb;   uart.wlast   = lsu.wlast;
            uart.bready  = lsu.bready;
            lsu.awready  = uart.awready; lsu.wready = uart.wready;
            lsu.bvalid   = uart.bvalid;  lsu.bresp  = uart.bresp;
            lsu.bid      = uart.bid;
          end
          T_CLINT: begin
            clint.awvalid = lsu.awvalid; clint.awaddr  = lsu.awaddr;
            clint.awid    = lsu.awid;    clint.awlen   = lsu.awlen;
            clint.awsize  = lsu.awsize;  clint.awburst = lsu.awburst;
            clint.wvalid  = lsu.wvalid;  clint.wdata   = lsu.wdata;
            clint.wstrb   = lsu.wstrb;   clint.wlast   = lsu.wlast;
            clint.bready  = lsu.bready;
            lsu.awready   = clint.awready; lsu.wready = clint.wready;
            lsu.bvalid    = clint.bvalid;  lsu.bresp  = clint.bresp;
            lsu.bid       = clint.bid;
          end
          default: begin
            sram.awvalid = lsu.awvalid; sram.awaddr  = lsu.awaddr;
            sram.awid    = lsu.awid;    sram.awlen   = lsu.awlen;
            sram.awsize  = lsu.awsize;  sram.awburst = lsu.awburst;
            sram.wvalid  = lsu.wvalid;  sram.wdata   = lsu.wdata;
            sram.wstrb   = lsu.wstrb;   sram.wlast   = lsu.wlast;
            sram.bready  = lsu.bready;
            lsu.awready  = sram.awready; lsu.wready = sram.wready;
            lsu.bvalid   = sram.bvalid;  lsu.bresp  = sram.bresp;
            lsu.bid      = sram.bid;
          end
        endcase
        if (lsu.bvalid && lsu.bready) wnext = W_IDLE;
      end
      W_ERR: begin
        lsu.awready = !w_acc;
        lsu.wready  = !w_done;
        lsu.bvalid  = w_done;
        lsu.bresp   = w_done ? 2'b11 : 2'b00;
        lsu.bid     = w_done ? wid_q : 4'd0;
        if (w_done && lsu.bready) wnext = W_IDLE;
      end
      default: wnext = W_IDLE;
    endcase
  end

endmodule

// File: tb/tb_ysyx_23060203_xbar.sv
// Directed bench for the LSU crossbar.
// Drives lsu as master and the three slaves by hand.
module tb_ysyx_23060203_xbar;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  ysyx_23060203_axi_if lsu_b ();
  ysyx_23060203_axi_if sram_b ();
  ysyx_23060203_axi_if uart_b ();
  ysyx_23060203_axi_if clint_b ();

  ysyx_23060203_xbar dut (
    .clock (clock),
    .reset (reset),
    .lsu   (lsu_b),
    .sram  (sram_b),
    .uart  (uart_b),
    .clint (clint_b)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic clr_slaves();
    sram_b.arready = 0; sram_b.rvalid = 0; sram_b.rresp = 0;
    sram_b.rdata = 0; sram_b.rlast = 0; sram_b.rid = 0;
    sram_b.awready = 0; sram_b.wready = 0; sram_b.bvalid = 0;
    sram_b.bresp = 0; sram_b.bid = 0;
    uart_b.arready = 0; uart_b.rvalid = 0; uart_b.rresp = 0;
    uart_b.rdata = 0; uart_b.rlast = 0; uart_b.rid = 0;
    uart_b.awready = 0; uart_b.wready = 0; uart_b.bvalid = 0;
    uart_b.bresp = 0; uart_b.bid = 0;
    clint_b.arready = 0; clint_b.rvalid = 0; clint_b.rresp = 0;
    clint_b.rdata = 0; clint_b.rlast = 0; clint_b.rid = 0;
    clint_b.awready = 0; clint_b.wready = 0; clint_b.bvalid = 0;
    clint_b.bresp = 0; clint_b.bid = 0;
  endtask

  initial begin
    lsu_b.arvalid = 0; lsu_b.araddr = 0; lsu_b.arid = 0;
    lsu_b.arlen = 0; lsu_b.arsize = 3'd2; lsu_b.arburst = 2'd1;
    lsu_b.rready = 0;
    lsu_b.awvalid = 0; lsu_b.awaddr = 0; lsu_b.awid = 0;
    lsu_b.awlen = 0; lsu_b.awsize = 3'd2; lsu_b.awburst = 2'd1;
    lsu_b.wvalid = 0; lsu_b.wdata = 0; lsu_b.wstrb = 4'hF;
    lsu_b.wlast = 0; lsu_b.bready = 0;
    clr_slaves();

    // reset state
    tick(); tick();
    reset = 0;
    #1;
    chk("rst_arready", lsu_b.arready, 0);
    chk("rst_rvalid", lsu_b.rvalid, 0);
    chk("rst_awready", lsu_b.awready, 0);
    chk("rst_wready", lsu_b.wready, 0);
    chk("rst_bvalid", lsu_b.bvalid, 0);
    chk("rst_sram_arv", sram_b.arvalid, 0);

    // SRAM read, arlen=3
    lsu_b.arvalid = 1; lsu_b.araddr = 32'h8000_0000;
    lsu_b.arlen = 3; lsu_b.arid = 2; lsu_b.rready = 1;
    #1;
    chk("sr_decode_gap", sram_b.arvalid, 0);
    tick();
    chk("sr_sram_arv", sram_b.arvalid, 1);
    chk("sr_sram_addr", sram_b.araddr, 32'h8000_0000);
    chk("sr_sram_len", sram_b.arlen, 3);
    chk("sr_uart_arv", uart_b.arvalid, 0);
    chk("sr_clint_arv", clint_b.arvalid, 0);
    chk("sr_arready0", lsu_b.arready, 0);
    sram_b.arready = 1;
    #1;
    chk("sr_arready1", lsu_b.arready, 1);
    tick();
    lsu_b.arvalid = 0; sram_b.arready = 0;
    for (int i = 0; i < 4; i++) begin
      sram_b.rvalid = 1; sram_b.rdata = 32'h100 + i;
      sram_b.rlast = (i == 3); sram_b.rid = 2;
      #1;
      chk("sr_beat_v", lsu_b.rvalid, 1);
      chk("sr_beat_d", lsu_b.rdata, 32'h100 + i);
      chk("sr_beat_last", lsu_b.rlast, (i == 3) ? 1 : 0);
      chk("sr_beat_id", lsu_b.rid, 2);
      tick();
    end
    #1;
    chk("sr_idle_after", lsu_b.rvalid, 0);
    chk("sr_idle_rready", sram_b.rready, 0);
    clr_slaves();

    // unmapped read, arlen=1, arid=5
    lsu_b.arvalid = 1; lsu_b.araddr = 32'h0000_0000;
    lsu_b.arlen = 1; lsu_b.arid = 5;
    tick();
    chk("er_arready", lsu_b.arready, 1);
    chk("er_rvalid0", lsu_b.rvalid, 0);
    chk("er_sram_arv", sram_b.arvalid, 0);
    lsu_b.arvalid = 0;
    tick();
    chk("er_arready_off", lsu_b.arready, 0);
    chk("er_b0_v", lsu_b.rvalid, 1);
    chk("er_b0_resp", lsu_b.rresp, 3);
    chk("er_b0_data", lsu_b.rdata, 0);
    chk("er_b0_id", lsu_b.rid, 5);
    chk("er_b0_last", lsu_b.rlast, 0);
    tick();
    chk("er_b1_v", lsu_b.rvalid, 1);
    chk("er_b1_last", lsu_b.rlast, 1);
    chk("er_b1_id", lsu_b.rid, 5);
    tick();
    chk("er_done", lsu_b.rvalid, 0);

    // UART window edge: 0x1000_1000 is outside, goes to DECERR
    lsu_b.arvalid = 1; lsu_b.araddr = 32'h1000_1000; lsu_b.arlen = 0;
    lsu_b.arid = 6;
    tick();
    chk("edge_uart_arv", uart_b.arvalid, 0);
    chk("edge_err_arready", lsu_b.arready, 1);
    lsu_b.arvalid = 0;
    tick();
    chk("edge_err_last", lsu_b.rlast, 1);
    tick();

    // unmapped write, 2 beats
    lsu_b.awvalid = 1; lsu_b.awaddr = 32'h3000_0000; lsu_b.awid = 7;
    lsu_b.awlen = 1; lsu_b.wvalid = 1; lsu_b.wdata = 32'hAAAA;
    lsu_b.wlast = 0; lsu_b.bready = 0;
    tick();
    chk("ew_awready", lsu_b.awready, 1);
    chk("ew_wready0", lsu_b.wready, 1);
    chk("ew_bvalid0", lsu_b.bvalid, 0);
    chk("ew_slave_awv",
        {29'd0, sram_b.awvalid, uart_b.awvalid, clint_b.awvalid}, 0);
    tick();
    lsu_b.awvalid = 0; lsu_b.wlast = 1; lsu_b.wdata = 32'hBBBB;
    #1;
    chk("ew_awready_off", lsu_b.awready, 0);
    chk("ew_wready1", lsu_b.wready, 1);
    chk("ew_bvalid_early", lsu_b.bvalid, 0);
    tick();
    lsu_b.wvalid = 0; lsu_b.wlast = 0;
    #1;
    chk("ew_wready_off", lsu_b.wready, 0);
    chk("ew_bvalid", lsu_b.bvalid, 1);
    chk("ew_bresp", lsu_b.bresp, 3);
    chk("ew_bid", lsu_b.bid, 7);
    tick();
    chk("ew_bhold", lsu_b.bvalid, 1);
    lsu_b.bready = 1;
    tick();
    chk("ew_done", lsu_b.bvalid, 0);

    // concurrent UART read + CLINT write
    lsu_b.arvalid = 1; lsu_b.araddr = 32'h1000_0000; lsu_b.arid = 1;
    lsu_b.arlen = 0;
    lsu_b.awvalid = 1; lsu_b.awaddr = 32'h0200_4000; lsu_b.awid = 3;
    lsu_b.awlen = 0; lsu_b.wvalid = 1; lsu_b.wdata = 32'hDEAD;
    lsu_b.wlast = 1; lsu_b.bready = 1;
    tick();
    chk("cc_uart_arv", uart_b.arvalid, 1);
    chk("cc_uart_awv", uart_b.awvalid, 0);
    chk("cc_uart_wv", uart_b.wvalid, 0);
    chk("cc_clint_awv", clint_b.awvalid, 1);
    chk("cc_clint_arv", clint_b.arvalid, 0);
    chk("cc_clint_wdata", clint_b.wdata, 32'hDEAD);
    chk("cc_clint_addr", clint_b.awaddr, 32'h0200_4000);
    chk("cc_sram_any",
        {30'd0, sram_b.arvalid, sram_b.awvalid}, 0);
    uart_b.arready = 1; clint_b.awready = 1; clint_b.wready = 1;
    #1;
    chk("cc_arready", lsu_b.arready, 1);
    chk("cc_awready", lsu_b.awready, 1);
    chk("cc_wready", lsu_b.wready, 1);
    tick();
    lsu_b.arvalid = 0; lsu_b.awvalid = 0; lsu_b.wvalid = 0;
    lsu_b.wlast = 0;
    clr_slaves();
    uart_b.rvalid = 1; uart_b.rdata = 32'h55; uart_b.rlast = 1;
    uart_b.rid = 1;
    clint_b.bvalid = 1; clint_b.bresp = 0; clint_b.bid = 3;
    #1;
    chk("cc_rdata", lsu_b.rdata, 32'h55);
    chk("cc_rid", lsu_b.rid, 1);
    chk("cc_rresp", lsu_b.rresp, 0);
    chk("cc_bvalid", lsu_b.bvalid, 1);
    chk("cc_bid", lsu_b.bid, 3);
    chk("cc_bresp", lsu_b.bresp, 0);
    tick();
    chk("cc_r_idle", lsu_b.rvalid, 0);
    chk("cc_w_idle", lsu_b.bvalid, 0);
    clr_slaves();
    lsu_b.bready = 0;

    // SRAM read with rready toggling
    lsu_b.arvalid = 1; lsu_b.araddr = 32'h8000_0040; lsu_b.arlen = 1;
    lsu_b.arid = 4; lsu_b.rready = 1;
    tick();
    sram_b.arready = 1;
    tick();
    lsu_b.arvalid = 0; sram_b.arready = 0;
    sram_b.rvalid = 1; sram_b.rdata = 32'hA0; sram_b.rlast = 0;
    sram_b.rid = 4;
    #1;
    chk("bp_b0", lsu_b.rdata, 32'hA0);
    tick();
    sram_b.rdata = 32'hB1; sram_b.rlast = 1; lsu_b.rready = 0;
    #1;
    chk("bp_rready_down0", sram_b.rready, 0);
    chk("bp_b1_held_v", lsu_b.rvalid, 1);
    tick();
    lsu_b.rready = 1;
    #1;
    chk("bp_rready_down1", sram_b.rready, 1);
    chk("bp_b1_data", lsu_b.rdata, 32'hB1);
    chk("bp_b1_last", lsu_b.rlast, 1);
    tick();
    lsu_b.rready = 0;
    #1;
    chk("bp_idle", lsu_b.rvalid, 0);
    clr_slaves();

    // DECERR read with rready toggling: rcnt moves only on handshake
    lsu_b.arvalid = 1; lsu_b.araddr = 32'h4000_0000; lsu_b.arlen = 1;
    lsu_b.arid = 9; lsu_b.rready = 0;
    tick();
    lsu_b.arvalid = 0;
    tick();
    chk("ebp_b0_last", lsu_b.rlast, 0);
    tick();
    chk("ebp_b0_hold", lsu_b.rlast, 0);
    lsu_b.rready = 1;
    tick();
    lsu_b.rready = 0;
    #1;
    chk("ebp_b1_v", lsu_b.rvalid, 1);
    chk("ebp_b1_last", lsu_b.rlast, 1);
    tick();
    chk("ebp_b1_hold", lsu_b.rlast, 1);
    lsu_b.rready = 1;
    tick();
    chk("ebp_idle", lsu_b.rvalid, 0);

    // reset during beat 2 of 4 of an SRAM read
    lsu_b.arvalid = 1; lsu_b.araddr = 32'h8000_0100; lsu_b.arlen = 3;
    lsu_b.arid = 1; lsu_b.rready = 1;
    tick();
    sram_b.arready = 1;
    tick();
    lsu_b.arvalid = 0; sram_b.arready = 0;
    sram_b.rvalid = 1; sram_b.rdata = 32'h10; sram_b.rlast = 0;
    tick();
    sram_b.rdata = 32'h11;
    reset = 1;
    tick();
    reset = 0;
    #1;
    chk("rb_rvalid", lsu_b.rvalid, 0);
    chk("rb_arready", lsu_b.arready, 0);
    chk("rb_sram_arv", sram_b.arvalid, 0);
    chk("rb_sram_rready", sram_b.rready, 0);
    chk("rb_wready", lsu_b.wready, 0);
    clr_slaves();

    // CLINT read after reset
    lsu_b.arvalid = 1; lsu_b.araddr = 32'h0200_0000; lsu_b.arlen = 0;
    lsu_b.arid = 4;
    tick();
    chk("pr_clint_arv", clint_b.arvalid, 1);
    chk("pr_sram_arv", sram_b.arvalid, 0);
    clint_b.arready = 1;
    tick();
    lsu_b.arvalid = 0; clint_b.arready = 0;
    clint_b.rvalid = 1; clint_b.rdata = 32'h77; clint_b.rlast = 1;
    clint_b.rid = 4;
    #1;
    chk("pr_rvalid", lsu_b.rvalid, 1);
    chk("pr_rdata", lsu_b.rdata, 32'h77);
    chk("pr_rid", lsu_b.rid, 4);
    tick();
    chk("pr_idle", lsu_b.rvalid, 0);
    clr_slaves();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
